// File: rtl/q_stream_packer_pkg.sv
// Shared definitions for the stream packer slice: default geometry,
// width helper and the default packet record {count, lanes}.
package tpu_q_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned PACK_N_DEF     = 4;
    localparam int unsigned BUF_DEPTH_DEF  = 4;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int unsigned clog2_plus1(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned COUNT_W_DEF = clog2_plus1(PACK_N_DEF);

    // Packet record at default geometry; lane 0 holds the oldest word.
    typedef struct packed {
        logic [COUNT_W_DEF-1:0]                   count;
        logic [PACK_N_DEF-1:0][DATA_WIDTH_DEF-1:0] lanes;
    } pkt_t;

endpackage

// File: rtl/q_stream_packer_if.sv
// Packet output handshake of the stream packer.
//   out_valid : head packet present
//   out_ready : downstream accepts head packet
//   out_data  : head packet lanes, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_count : number of valid lanes in head packet
interface q_stream_packer_if
    import tpu_q_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PACK_N     = PACK_N_DEF
);
    localparam int unsigned COUNT_W = clog2_plus1(PACK_N);

    logic                         out_valid;
    logic                         out_ready;
    logic [PACK_N*DATA_WIDTH-1:0] out_data;
    logic [COUNT_W-1:0]           out_count;

    modport master (output out_valid, output out_data, output out_count, input out_ready);
    modport slave  (input out_valid, input out_data, input out_count, output out_ready);

endinterface

// File: rtl/q_stream_packer_fifo.sv
// Generic circular packet buffer.
//   push/push_data : write request; dropped (drop_c) when full with no pop
//   pop            : remove head; ignored while empty
//   head_c         : record at the read pointer (mux of storage registers)
//   empty_c        : no record held
//   level          : records currently held, 0..DEPTH
module q_pkt_fifo
    import tpu_q_pkg::*;
#(
    parameter type         T     = pkt_t,
    parameter int unsigned DEPTH = BUF_DEPTH_DEF,
    localparam int unsigned PTR_W   = $clog2(DEPTH),
    localparam int unsigned LEVEL_W = clog2_plus1(DEPTH)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               push,
    input  T                   push_data,
    input  logic               pop,
    output T                   head_c,
    output logic               empty_c,
    output logic               drop_c,
    output logic [LEVEL_W-1:0] level
);

    T                   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               full_c;
    logic               do_push_c;
    logic               do_pop_c;

    // A pop frees the slot in the same edge, so a full buffer still accepts.
    always_comb begin
        empty_c   = (level == '0);
        full_c    = (level == LEVEL_W'(DEPTH));
        do_pop_c  = pop && !empty_c;
        do_push_c = push && (!full_c || do_pop_c);
        drop_c    = push && full_c && !do_pop_c;
        head_c    = mem[rd_ptr];
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/q_stream_packer.sv
// Packs an unstallable enable-tagged word stream into PACK_N-word packets
// and buffers them for a valid/ready consumer.
//   enable_in/data_in : stream word, no backpressure
//   flush             : close the current partial packet
//   pkt_if            : packet output handshake (master)
//   overflow          : sticky, a packet was dropped on a full buffer
//   level             : packets currently buffered
module q_stream_packer
    import tpu_q_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PACK_N     = PACK_N_DEF,
    parameter int unsigned BUF_DEPTH  = BUF_DEPTH_DEF,
    localparam int unsigned COUNT_W   = clog2_plus1(PACK_N),
    localparam int unsigned LEVEL_W   = clog2_plus1(BUF_DEPTH),
    localparam int unsigned FILL_W    = $clog2(PACK_N)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  flush,
    q_stream_packer_if.master     pkt_if,
    output logic                  overflow,
    output logic [LEVEL_W-1:0]    level
);

    typedef struct packed {
        logic [COUNT_W-1:0]                   count;
        logic [PACK_N-1:0][DATA_WIDTH-1:0]    lanes;
    } rec_t;

    logic [PACK_N-1:0][DATA_WIDTH-1:0] lanes_q;
    logic [PACK_N-1:0][DATA_WIDTH-1:0] lanes_next_c;
    logic [FILL_W-1:0]                 fill_q;
    logic                              push_c;
    rec_t                              push_rec_c;
    rec_t                              head_c;
    logic                              empty_c;
    logic                              drop_c;

    // Packet as it would look after this edge; pushed when full or flushed.
    always_comb begin
        lanes_next_c = lanes_q;
        if (enable_in) begin
            lanes_next_c[fill_q] = data_in;
        end
        push_c = (enable_in && (fill_q == FILL_W'(PACK_N - 1)))
              || (flush && ((fill_q != '0) || enable_in));
        push_rec_c.count = COUNT_W'(fill_q) + COUNT_W'(enable_in);
        push_rec_c.lanes = lanes_next_c;
    end

    // Assembly register, fill counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lanes_q  <= '0;
            fill_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_c) begin
                lanes_q <= '0;
                fill_q  <= '0;
            end else if (enable_in) begin
                lanes_q <= lanes_next_c;
                fill_q  <= fill_q + FILL_W'(1);
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    q_pkt_fifo #(
        .T     (rec_t),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push_c),
        .push_data (push_rec_c),
        .pop       (pkt_if.out_ready),
        .head_c    (head_c),
        .empty_c   (empty_c),
        .drop_c    (drop_c),
        .level     (level)
    );

    // Outputs depend only on buffer registers, never on the stream inputs.
    assign pkt_if.out_valid = !empty_c;
    assign pkt_if.out_data  = head_c.lanes;
    assign pkt_if.out_count = head_c.count;

endmodule

// File: tb/tb_q_stream_packer.sv
// Directed self-checking bench for q_stream_packer at default geometry.
module tb_q_stream_packer;

    localparam int unsigned DW = 32;
    localparam int unsigned PN = 4;
    localparam int unsigned BD = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          enable_in;
    logic [DW-1:0] data_in;
    logic          flush;
    logic          overflow;
    logic [2:0]    level;

    q_stream_packer_if #(.DATA_WIDTH(DW), .PACK_N(PN)) pif ();

    q_stream_packer #(
        .DATA_WIDTH (DW),
        .PACK_N     (PN),
        .BUF_DEPTH  (BD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable_in (enable_in),
        .data_in   (data_in),
        .flush     (flush),
        .pkt_if    (pif),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [DW-1:0] d, input logic fl);
        enable_in = en;
        data_in   = d;
        flush     = fl;
        step();
        enable_in = 1'b0;
        data_in   = '0;
        flush     = 1'b0;
    endtask

    function automatic logic [127:0] pk(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] wd(input int p, input int k);
        return 32'(p * 16 + k);
    endfunction

    function automatic logic [127:0] pkt(input int p);
        return pk(wd(p, 0), wd(p, 1), wd(p, 2), wd(p, 3));
    endfunction

    task automatic send_pkt(input int p);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, wd(p, k), 1'b0);
        end
    endtask

    logic [31:0] gap_d [7];
    logic        gap_e [7];

    initial begin
        rstn = 1'b0; enable_in = 1'b0; data_in = '0; flush = 1'b0; pif.out_ready = 1'b0;
        step(); step();
        check("rst_valid", 128'(pif.out_valid), 128'(0));
        check("rst_data", pif.out_data, 128'(0));
        check("rst_count", 128'(pif.out_count), 128'(0));
        check("rst_ovf", 128'(overflow), 128'(0));
        check("rst_level", 128'(level), 128'(0));
        rstn = 1'b1;

        // Full packet with ready high
        pif.out_ready = 1'b1;
        drive(1'b1, 32'h11, 1'b0);
        check("t1_w1_valid", 128'(pif.out_valid), 128'(0));
        drive(1'b1, 32'h22, 1'b0);
        drive(1'b1, 32'h33, 1'b0);
        check("t1_w3_valid", 128'(pif.out_valid), 128'(0));
        drive(1'b1, 32'h44, 1'b0);
        check("t1_valid", 128'(pif.out_valid), 128'(1));
        check("t1_data", pif.out_data, pk(32'h11, 32'h22, 32'h33, 32'h44));
        check("t1_count", 128'(pif.out_count), 128'(4));
        check("t1_level", 128'(level), 128'(1));
        step();
        check("t1_pop_valid", 128'(pif.out_valid), 128'(0));
        check("t1_pop_level", 128'(level), 128'(0));

        // Gapped stream
        gap_e = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        gap_d = '{32'hA, 32'h0, 32'hB, 32'h0, 32'h0, 32'hC, 32'hD};
        for (int i = 0; i < 6; i++) begin
            drive(gap_e[i], gap_d[i], 1'b0);
            check($sformatf("t2_gap%0d_valid", i), 128'(pif.out_valid), 128'(0));
        end
        drive(gap_e[6], gap_d[6], 1'b0);
        check("t2_valid", 128'(pif.out_valid), 128'(1));
        check("t2_data", pif.out_data, pk(32'hA, 32'hB, 32'hC, 32'hD));
        check("t2_count", 128'(pif.out_count), 128'(4));
        step();

        // Flush variants
        drive(1'b1, 32'h5, 1'b0);
        drive(1'b1, 32'h6, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        check("t3a_valid", 128'(pif.out_valid), 128'(1));
        check("t3a_count", 128'(pif.out_count), 128'(2));
        check("t3a_data", pif.out_data, pk(32'h5, 32'h6, 32'h0, 32'h0));
        step();
        check("t3a_pop_valid", 128'(pif.out_valid), 128'(0));
        drive(1'b1, 32'h5, 1'b0);
        drive(1'b1, 32'h6, 1'b0);
        drive(1'b1, 32'h7, 1'b1);
        check("t3b_count", 128'(pif.out_count), 128'(3));
        check("t3b_data", pif.out_data, pk(32'h5, 32'h6, 32'h7, 32'h0));
        step();
        drive(1'b0, 32'h0, 1'b1);
        check("t3c_noop_valid", 128'(pif.out_valid), 128'(0));
        check("t3c_noop_level", 128'(level), 128'(0));
        drive(1'b1, 32'h9, 1'b1);
        check("t3d_count", 128'(pif.out_count), 128'(1));
        check("t3d_data", pif.out_data, pk(32'h9, 32'h0, 32'h0, 32'h0));
        step();

        // Overflow with ready low
        pif.out_ready = 1'b0;
        for (int p = 1; p <= 4; p++) begin
            send_pkt(p);
            check($sformatf("t4_head_p%0d", p), pif.out_data, pkt(1));
        end
        check("t4_level_full", 128'(level), 128'(4));
        check("t4_ovf_before", 128'(overflow), 128'(0));
        send_pkt(5);
        check("t4_ovf", 128'(overflow), 128'(1));
        check("t4_level", 128'(level), 128'(4));
        check("t4_head_after", pif.out_data, pkt(1));
        step(); step();
        check("t4_ovf_sticky", 128'(overflow), 128'(1));
        pif.out_ready = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            check($sformatf("t4_drain_p%0d", p), pif.out_data, pkt(p));
            step();
        end
        check("t4_drained_valid", 128'(pif.out_valid), 128'(0));
        check("t4_drained_ovf", 128'(overflow), 128'(1));

        // Push and pop on the same edge while full
        pif.out_ready = 1'b0;
        rstn = 1'b0; step(); rstn = 1'b1;
        check("t5_ovf_clr", 128'(overflow), 128'(0));
        for (int p = 1; p <= 4; p++) send_pkt(p);
        for (int k = 0; k < 3; k++) drive(1'b1, wd(5, k), 1'b0);
        pif.out_ready = 1'b1;
        drive(1'b1, wd(5, 3), 1'b0);
        check("t5_level", 128'(level), 128'(4));
        check("t5_ovf", 128'(overflow), 128'(0));
        for (int p = 2; p <= 5; p++) begin
            check($sformatf("t5_order_p%0d", p), pif.out_data, pkt(p));
            step();
        end
        check("t5_empty_level", 128'(level), 128'(0));

        // Reset mid-operation
        pif.out_ready = 1'b0;
        send_pkt(1);
        send_pkt(2);
        drive(1'b1, 32'h77, 1'b0);
        drive(1'b1, 32'h78, 1'b0);
        check("t6_level_pre", 128'(level), 128'(2));
        rstn = 1'b0; step(); rstn = 1'b1;
        check("t6_valid", 128'(pif.out_valid), 128'(0));
        check("t6_data", pif.out_data, 128'(0));
        check("t6_count", 128'(pif.out_count), 128'(0));
        check("t6_ovf", 128'(overflow), 128'(0));
        check("t6_level", 128'(level), 128'(0));
        drive(1'b1, 32'h1, 1'b0);
        drive(1'b1, 32'h2, 1'b0);
        drive(1'b1, 32'h3, 1'b0);
        check("t6_partial_valid", 128'(pif.out_valid), 128'(0));
        drive(1'b1, 32'h4, 1'b0);
        check("t6_clean_data", pif.out_data, pk(32'h1, 32'h2, 32'h3, 32'h4));
        check("t6_clean_count", 128'(pif.out_count), 128'(4));
        check("t6_clean_level", 128'(level), 128'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/q_stream_packer.md
Name: q_stream_packer

Overview:
Receive-side companion to the fixed-latency delay queue used on systolic-array edges.
- Consumes the enable-tagged word stream that the queue emits. The stream has no backpressure and cannot be stalled.
- Packs PACK_N consecutive valid words into one wide packet.
- Buffers packets in a small circular buffer and presents them downstream on a valid/ready handshake, e.g. to the result writeback path.
- Drops packets and flags overflow when the buffer is full.

Parameters:
DATA_WIDTH, 32, width of one stream word
PACK_N, 4, words per packet (>=2)
BUF_DEPTH, 4, packet buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock
rstn  input  1  reset, synchronous, active-low
enable_in  input  1  word valid on stream input; no stall possible
data_in  input  DATA_WIDTH  stream word
flush  input  1  close current partial packet
out_valid  output  1  buffer head holds a packet
out_ready  input  1  downstream accepts head packet
out_data  output  PACK_N*DATA_WIDTH  head packet; lane k at [k*DATA_WIDTH +: DATA_WIDTH]
out_count  output  $clog2(PACK_N+1)  number of valid lanes in head packet (1..PACK_N)
overflow  output  1  sticky: a packet was dropped
level  output  $clog2(BUF_DEPTH+1)  packets currently buffered

Behaviour:
Reset:
- All outputs are 0.
- fill counter, pointers and the assembly register are cleared.
- Reset mid-operation discards the partial packet and all buffered packets.

Assembly:
- fill_cnt ranges 0..PACK_N-1.
- On each clk edge with enable_in=1, data_in is written to lane fill_cnt and fill_cnt increments.
- Lane 0 is always the oldest word.

Push:
- A push occurs on the edge where enable_in=1 and fill_cnt=PACK_N-1. The packet pushed contains the current word, with count=PACK_N.
- fill_cnt returns to 0 and the assembly lanes are zeroed on the same edge.

Flush:
- flush=1 with fill_cnt>0 pushes a partial packet with count=fill_cnt+enable_in. The current word is included if enable_in=1.
- Unused lanes are zero.
- flush=1 with fill_cnt=0 and enable_in=1 pushes a 1-word packet.
- flush=1 with fill_cnt=0 and enable_in=0 is a no-op.
- A flush on the edge that completes a full packet is identical to a normal push.

Latency:
- The packet pushed at edge N is visible at out_valid/out_data/out_count after edge N, i.e. in cycle N+1, when the buffer was empty.
- No combinational path exists from enable_in or flush to the outputs.

Pop:
- A pop occurs on an edge with out_valid=1 and out_ready=1.
- out_data/out_count must be held stable while out_valid=1 and out_ready=0.
- out_valid is never deasserted without a pop.

Full buffer:
- A push while level=BUF_DEPTH with no simultaneous pop drops the packet and sets overflow.
- The assembly state still resets as for a normal push.
- A push and a pop on the same edge while full are both performed; level is unchanged and nothing is dropped.

Empty buffer:
- A push and a pop cannot coincide, since out_valid=0.
- out_ready is ignored while out_valid=0.

Overflow:
- overflow is cleared only by reset.

Pointers and level:
- rd_ptr/wr_ptr are $clog2(BUF_DEPTH) bits wide and wrap naturally.
- level = push - pop, updated every edge, saturating at 0..BUF_DEPTH.
- out_data for an empty buffer is don't-care, but 0 after reset.

Decomposition:
Package tpu_q_pkg:
- localparams for default DATA_WIDTH/PACK_N/BUF_DEPTH.
- Function clog2_plus1 for count/level widths.
- Typedef for the packet record {count, lanes}.

Sub-module q_pkt_fifo:
- Generic circular buffer with push/pop, full/empty, level.
- Holds the packet record.
- q_stream_packer instantiates it and owns the assembly/flush logic.

Test Plan:
- Enable_in=1 for 4 cycles with data 0x11,0x22,0x33,0x44, out_ready=1 -> one cycle after the 4th edge out_valid=1, out_data=0x44_33_22_11 (lane0 LSB), out_count=4; popped next edge; level returns 0.
- Gapped stream: words 0xA,bubble,0xB,bubble,bubble,0xC,0xD -> a single packet {0xD,0xC,0xB,0xA}; no packet before the 0xD edge.
- 2 words 0x5,0x6 then flush=1 with enable_in=0 -> out_count=2, out_data lanes2..3=0. Flush with enable_in=1 carrying 0x7 after 0x5,0x6 -> count=3.
- out_ready=0, 5 full packets streamed -> level=4; 5th packet dropped, overflow=1 and stays 1; head packet equals the 1st packet and is stable throughout.
- Full buffer, out_ready=1 on the same edge as the 5th packet's completion -> no drop, overflow=0, level stays 4; the packets pop in order 2,3,4,5.
- rstn=0 for 1 cycle after 2 words and with 2 buffered packets -> all outputs 0, level=0. The next 4 words form a clean packet starting at lane 0.
